sopc_unified_mem: RTL and testbench

SOPC_UNIFIED_MEM -- requirements
Module: sopc_unified_mem

---
 rtl/sopc_unified_mem.sv | 128 ++++++++++++
 tb/tb_sopc_unified_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sopc_unified_mem.sv
// Shared single-port memory for an instruction read port and a data read/write port.
// One access is in flight at a time, sequenced IDLE -> WAIT -> ACCESS -> DONE.
module sopc_unified_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_ce_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_data_o,
  output logic                inst_ready_o,
  input  logic                data_ce_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [DATA_W-1:0]   data_data_i,
  output logic [DATA_W-1:0]   data_data_o,
  output logic                data_ready_o,
  output logic                busy_o
);

  localparam int SEL_W    = DATA_W / 8;
  localparam int OFF_W    = $clog2(SEL_W);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = 4;
  localparam int CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               last_data_reg;
  logic               grant_data_reg;
  logic               we_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  inst_rdata_reg;
  logic [DATA_W-1:0]  data_rdata_reg;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               grant_data;
  logic [IDX_W-1:0]   inst_idx;
  logic [IDX_W-1:0]   data_idx;
  logic               unused_addr_bits;

  // Upper address bits beyond the array size are dropped, so addresses wrap.
  assign inst_idx         = inst_addr_i[OFF_W +: IDX_W];
  assign data_idx         = data_addr_i[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{inst_addr_i, data_addr_i};

  // Round-robin ties go to whichever port was not granted last.
  assign grant_data = data_ce_i && (!inst_ce_i || (ARB_MODE == 0) || !last_data_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (inst_ce_i || data_ce_i) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_reg == '0) state_next = S_ACCESS;
      S_ACCESS: state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    inst_ready_o = (state_reg == S_DONE) && !grant_data_reg;
    data_ready_o = (state_reg == S_DONE) &&  grant_data_reg;
    busy_o       = (state_reg != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      last_data_reg  <= 1'b0;
      grant_data_reg <= 1'b0;
      we_reg         <= 1'b0;
      idx_reg        <= '0;
      sel_reg        <= '0;
      wdata_reg      <= '0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (inst_ce_i || data_ce_i) begin
            grant_data_reg <= grant_data;
            last_data_reg  <= grant_data;
            idx_reg        <= grant_data ? data_idx : inst_idx;
            we_reg         <= grant_data && data_we_i;
            sel_reg        <= data_sel_i;
            wdata_reg      <= data_data_i;
            cnt_reg        <= CNT_W'(CNT_LOAD);
          end
        end
        S_WAIT: if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        S_ACCESS: begin
          if (!we_reg) begin
            if (grant_data_reg) data_rdata_reg <= mem[idx_reg];
            else                inst_rdata_reg <= mem[idx_reg];
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never reset; a reset during an access leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == S_ACCESS && we_reg) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (sel_reg[i]) mem[idx_reg][i*8 +: 8] <= wdata_reg[i*8 +: 8];
      end
    end
  end

  assign inst_data_o = inst_rdata_reg;
  assign data_data_o = data_rdata_reg;

endmodule

// File: tb/tb_sopc_unified_mem.sv
// Directed bench for sopc_unified_mem: three instances cover WAIT_CYCLES 1/0 and both
// arbitration modes; a vector table drives the main access cases.
module tb_sopc_unified_mem;

  localparam int ND = 3;
  localparam int WC [ND] = '{1, 1, 0};
  localparam int AM [ND] = '{0, 1, 0};

  logic        clk;
  logic        rst;
  logic        inst_ce   [ND];
  logic [31:0] inst_addr [ND];
  logic [31:0] inst_data [ND];
  logic        inst_rdy  [ND];
  logic        data_ce   [ND];
  logic        data_we   [ND];
  logic [31:0] data_addr [ND];
  logic [3:0]  data_sel  [ND];
  logic [31:0] data_wd   [ND];
  logic [31:0] data_rd   [ND];
  logic        data_rdy  [ND];
  logic        busy      [ND];

  int n_cmp = 0;
  int n_fail = 0;
  int grant_log [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    sopc_unified_mem #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(1024),
      .WAIT_CYCLES(WC[gi]), .ARB_MODE(AM[gi])
    ) dut (
      .clk(clk), .rst(rst),
      .inst_ce_i(inst_ce[gi]), .inst_addr_i(inst_addr[gi]),
      .inst_data_o(inst_data[gi]), .inst_ready_o(inst_rdy[gi]),
      .data_ce_i(data_ce[gi]), .data_we_i(data_we[gi]), .data_addr_i(data_addr[gi]),
      .data_sel_i(data_sel[gi]), .data_data_i(data_wd[gi]),
      .data_data_o(data_rd[gi]), .data_ready_o(data_rdy[gi]), .busy_o(busy[gi])
    );
  end

  typedef struct {
    bit          is_inst;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one access on instance d; returns read value, ready latency and busy-cycle count.
  task automatic do_access(input int d, input bit is_inst, input bit we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int lat, output int busy_cnt);
    bit seen;
    if (is_inst) begin
      inst_ce[d] = 1'b1; inst_addr[d] = addr;
    end else begin
      data_ce[d] = 1'b1; data_we[d] = we; data_addr[d] = addr; data_sel[d] = sel; data_wd[d] = wdata;
    end
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy[d]) busy_cnt++;
      seen = is_inst ? inst_rdy[d] : data_rdy[d];
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout dut%0d: no ready within 20 cycles", d);
    end
    chk("other_ready_low", {31'b0, is_inst ? data_rdy[d] : inst_rdy[d]}, 32'd0);
    rdata = is_inst ? inst_data[d] : data_rd[d];
    inst_ce[d] = 1'b0; data_ce[d] = 1'b0;
    @(posedge clk); #1;
    chk("ready_pulse_end", {31'b0, is_inst ? inst_rdy[d] : data_rdy[d]}, 32'd0);
    chk("busy_after_done", {31'b0, busy[d]}, 32'd0);
  endtask

  // Both ports request; logs which port is granted, optionally dropping a port once served.
  task automatic arb_run(input int d, input int n, input bit drop);
    int k = 0;
    int cyc = 0;
    inst_ce[d] = 1'b1; inst_addr[d] = 32'h4;
    data_ce[d] = 1'b1; data_we[d] = 1'b0; data_addr[d] = 32'h10;
    while (k < n && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (inst_rdy[d] && data_rdy[d]) chk("both_ready", 32'd1, 32'd0);
      if (data_rdy[d]) begin
        grant_log[k] = 1; k++;
        if (drop) data_ce[d] = 1'b0;
      end else if (inst_rdy[d]) begin
        grant_log[k] = 2; k++;
        if (drop) inst_ce[d] = 1'b0;
      end
    end
    if (k < n) begin
      n_cmp++; n_fail++;
      $display("FAIL arb_timeout dut%0d: %0d of %0d grants seen", d, k, n);
    end
    inst_ce[d] = 1'b0; data_ce[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, bc;

    vecs[0]  = '{0, 1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0000_0000};
    vecs[1]  = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_3344};
    vecs[2]  = '{0, 1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h1122_3344};
    vecs[3]  = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[4]  = '{0, 1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'h11BB_33DD};
    vecs[5]  = '{0, 0, 32'h0000_1004, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{1, 0, 32'h8000_0010, 4'h0, 32'h0,         32'h11BB_33DD};
    vecs[7]  = '{0, 1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[9]  = '{0, 1, 32'h0000_0020, 4'hF, 32'h1234_5678, 32'h11BB_33DD};
    vecs[10] = '{1, 0, 32'h0000_0020, 4'h0, 32'h0,         32'h1234_5678};
    vecs[11] = '{0, 0, 32'h0000_0013, 4'hF, 32'h0,         32'h11BB_33DD};

    for (int d = 0; d < ND; d++) begin
      inst_ce[d] = 0; inst_addr[d] = 0; data_ce[d] = 0; data_we[d] = 0;
      data_addr[d] = 0; data_sel[d] = 0; data_wd[d] = 0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_busy%0d", d), {31'b0, busy[d]}, 32'd0);
      chk($sformatf("reset_ready%0d", d), {30'b0, inst_rdy[d], data_rdy[d]}, 32'd0);
      chk($sformatf("reset_data%0d", d), data_rd[d] | inst_data[d], 32'd0);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_access(0, vecs[i].is_inst, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, rd, lat, bc);
      $display("vec %0d: %s %s addr=0x%08h sel=%h wd=0x%08h rd=0x%08h lat=%0d",
               i, vecs[i].is_inst ? "inst" : "data", vecs[i].we ? "W" : "R",
               vecs[i].addr, vecs[i].sel, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 32'd3);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd3);
    end

    // Reset during the wait state of a write: outputs clear at once, array keeps 0x12345678.
    data_ce[0] = 1'b1; data_we[0] = 1'b1; data_addr[0] = 32'h20; data_sel[0] = 4'hF; data_wd[0] = 32'h55;
    @(posedge clk); #1;
    chk("abort_busy_in_wait", {31'b0, busy[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy[0]}, 32'd0);
    chk("abort_ready", {30'b0, inst_rdy[0], data_rdy[0]}, 32'd0);
    chk("abort_data_o", data_rd[0], 32'd0);
    chk("abort_inst_o", inst_data[0], 32'd0);
    data_ce[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_access(0, 0, 0, 32'h20, 4'hF, 32'h0, rd, lat, bc);
    $display("abort readback: addr=0x00000020 rd=0x%08h lat=%0d", rd, lat);
    chk("abort_readback", rd, 32'h1234_5678);
    chk("abort_readback_latency", lat, 32'd3);

    arb_run(0, 2, 1'b1);
    $display("arb fixed: grants %0d %0d", grant_log[0], grant_log[1]);
    chk("arb0_first", grant_log[0], 32'd1);
    chk("arb0_second", grant_log[1], 32'd2);

    arb_run(1, 3, 1'b0);
    $display("arb rr: grants %0d %0d %0d", grant_log[0], grant_log[1], grant_log[2]);
    chk("arb1_first", grant_log[0], 32'd1);
    chk("arb1_second", grant_log[1], 32'd2);
    chk("arb1_third", grant_log[2], 32'd1);

    do_access(2, 0, 1, 32'h8, 4'hF, 32'hCAFE_F00D, rd, lat, bc);
    $display("wait0 write: addr=0x00000008 lat=%0d busy=%0d", lat, bc);
    chk("w0_write_latency", lat, 32'd2);
    do_access(2, 0, 0, 32'h8, 4'hF, 32'h0, rd, lat, bc);
    $display("wait0 read: addr=0x00000008 rd=0x%08h lat=%0d busy=%0d", rd, lat, bc);
    chk("w0_read_data", rd, 32'hCAFE_F00D);
    chk("w0_read_latency", lat, 32'd2);
    chk("w0_busy_cycles", bc, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
